kbd_host_tx: RTL and testbench



---
 rtl/kbd_pkg.sv | 24 ++
 rtl/ps2_edge_filter.sv | 25 ++
 rtl/kbd_host_tx.sv | 189 ++++++++++++++++++
 tb/tb_kbd_host_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared PS/2 keyboard definitions: host transmitter states, command bytes and
// the odd-parity helper used when framing a host-to-device byte.
package kbd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SEND,
    ACK,
    WAIT_IDLE
  } tx_state_e;

  localparam logic [7:0] KBD_CMD_LEDS   = 8'hED;
  localparam logic [7:0] KBD_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] KBD_CMD_RESET  = 8'hFF;
  localparam logic [7:0] KBD_RSP_ACK    = 8'hFA;

  // Parity bit that makes the 8 data bits plus parity contain an odd number of ones.
  function automatic logic odd_parity_bit(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// Glitch filter for the raw PS/2 clock pad: a falling edge is only reported
// after four high samples are followed by four low samples.
module ps2_edge_filter (
  input  logic clk,
  input  logic reset,
  input  logic ps2clk_i,
  output logic fall_o,
  output logic level_o
);

  logic [7:0] hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= {hist_q[6:0], ps2clk_i};
    end
  end

  assign fall_o  = (hist_q[7:4] == 4'hF) && (hist_q[3:0] == 4'h0);
  // Second stage of the history doubles as a synchronised clock level.
  assign level_o = hist_q[1];

endmodule

// File: rtl/kbd_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, requests to send,
// shifts out data/parity/stop on device clock falls and checks the ack bit.
module kbd_host_tx
  import kbd_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       timeout,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic       ps2clk_oe,
  output logic       ps2data_oe
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_START = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic             INH_ONE   = (INHIBIT_CYCLES == 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  tx_state_e        state_q;
  logic [9:0]       shift_q;
  logic [3:0]       bit_cnt_q;
  logic [INH_W-1:0] inh_cnt_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [1:0]       idle_cnt_q;
  logic             data_meta_q;
  logic             data_s_q;
  logic             tx_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             nack_q;
  logic             timeout_q;
  logic             clk_oe_q;
  logic             data_oe_q;

  logic             fall;
  logic             clk_level;
  logic             par_d;

  ps2_edge_filter u_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2clk_i (ps2clk),
    .fall_o   (fall),
    .level_o  (clk_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_meta_q <= 1'b0;
      data_s_q    <= 1'b0;
    end else begin
      data_meta_q <= ps2data;
      data_s_q    <= data_meta_q;
    end
  end

  assign par_d = odd_parity_bit(tx_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      idle_cnt_q <= '0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
      timeout_q  <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_valid && tx_ready_q) begin
            shift_q    <= {1'b1, par_d, tx_data};
            inh_cnt_q  <= '0;
            clk_oe_q   <= 1'b1;
            data_oe_q  <= INH_ONE;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (inh_cnt_q == INH_LAST) begin
            data_oe_q <= 1'b1;
            state_q   <= START;
          end else begin
            inh_cnt_q <= inh_cnt_q + INH_W'(1);
            // Start bit goes low one cycle before the inhibit ends.
            if (inh_cnt_q == INH_START) begin
              data_oe_q <= 1'b1;
            end
          end
        end
        START: begin
          clk_oe_q  <= 1'b0;
          bit_cnt_q <= '0;
          to_cnt_q  <= '0;
          state_q   <= SEND;
        end
        SEND, ACK, WAIT_IDLE: begin
          if (to_cnt_q == TO_LAST) begin
            timeout_q  <= 1'b1;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
            if (state_q == SEND) begin
              if (fall) begin
                data_oe_q <= ~shift_q[0];
                shift_q   <= {1'b0, shift_q[9:1]};
                bit_cnt_q <= bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd9) begin
                  state_q <= ACK;
                end
              end
            end else if (state_q == ACK) begin
              if (fall) begin
                if (data_s_q) begin
                  nack_q     <= 1'b1;
                  clk_oe_q   <= 1'b0;
                  data_oe_q  <= 1'b0;
                  tx_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= IDLE;
                end else begin
                  idle_cnt_q <= '0;
                  state_q    <= WAIT_IDLE;
                end
              end
            end else begin
              // Bus must read idle (both lines high) for four cycles in a row.
              if (clk_level && data_s_q) begin
                if (idle_cnt_q == 2'd3) begin
                  done_q     <= 1'b1;
                  tx_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= IDLE;
                end else begin
                  idle_cnt_q <= idle_cnt_q + 2'd1;
                end
              end else begin
                idle_cnt_q <= '0;
              end
            end
          end
        end
        default: begin
          clk_oe_q   <= 1'b0;
          data_oe_q  <= 1'b0;
          tx_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready   = tx_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign nack       = nack_q;
  assign timeout    = timeout_q;
  assign ps2clk_oe  = clk_oe_q;
  assign ps2data_oe = data_oe_q;

endmodule

// File: tb/tb_kbd_host_tx.sv
// Bench for kbd_host_tx: a behavioural PS/2 device drives the open-drain bus
// and a per-cycle compare process checks the DUT against a frame-level model.
module tb_kbd_host_tx;
  import kbd_pkg::*;

  localparam int IC  = 25;
  localparam int TO  = 3000;
  localparam int BIG = 32'h7fffffff;
  localparam int M_ACK = 0, M_NACK = 1, M_SILENT = 2, M_RST = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, nack, timeout;
  logic       ps2clk_oe, ps2data_oe;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       bus_clk, bus_data;

  assign bus_clk  = ~(ps2clk_oe | dev_clk_low);
  assign bus_data = ~(ps2data_oe | dev_data_low);

  kbd_host_tx #(.INHIBIT_CYCLES(IC), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .nack       (nack),
    .timeout    (timeout),
    .ps2clk     (bus_clk),
    .ps2data    (bus_data),
    .ps2clk_oe  (ps2clk_oe),
    .ps2data_oe (ps2data_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Frame-level model state, written by the stimulus thread.
  bit         frame_on = 1'b0;
  int         mode = M_ACK;
  int         acc_edge = 0;
  int         end_edge = BIG;
  int         q_edge = -1;
  int         fall_edge [1:11];
  logic [7:0] m_byte = 8'h00;
  logic [10:1] last_rx = '0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      if (miscompares <= 30)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int n);
    if (n >= 1 && n <= 8) return b[n-1];
    if (n == 9) return ($countones(b) % 2) == 0;
    return 1'b1;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int  nef;
    int  k;
    bit  win;
    bit  exp_busy;
    bit  e_clk;
    bit  e_data;
    if (!reset) begin
      win = frame_on && mode == M_ACK && q_edge >= 0 && end_edge == BIG &&
            cyc > q_edge && cyc <= q_edge + 12;
      if (done) begin
        chk("done_window", int'(win), 1);
        if (win) end_edge = cyc;
      end else if (frame_on && mode == M_ACK && q_edge >= 0 && end_edge == BIG &&
                   cyc > q_edge + 12) begin
        chk("done_missing", int'(done), 1);
        end_edge = cyc;
      end
      exp_busy = frame_on && cyc < end_edge;
      chk("busy", int'(busy), int'(exp_busy));
      chk("tx_ready", int'(tx_ready), int'(!exp_busy));
      chk("nack", int'(nack), int'(frame_on && mode == M_NACK && cyc == end_edge));
      chk("timeout", int'(timeout), int'(frame_on && mode == M_SILENT && cyc == end_edge));
      e_clk  = 1'b0;
      e_data = 1'b0;
      if (exp_busy) begin
        k = cyc - acc_edge;
        if (k <= IC) begin
          e_clk  = 1'b1;
          e_data = (k >= IC - 1);
        end else begin
          nef = 0;
          for (int f = 1; f <= 11; f++)
            if (fall_edge[f] >= 0 && cyc >= fall_edge[f] + 5) nef++;
          if (nef == 0)       e_data = 1'b1;
          else if (nef <= 10) e_data = !frame_bit(m_byte, nef);
          else                e_data = 1'b0;
        end
      end
      chk("ps2clk_oe", int'(ps2clk_oe), int'(e_clk));
      chk("ps2data_oe", int'(ps2data_oe), int'(e_data));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int md, input bit hold);
    int          h, g, waited;
    logic [10:1] rx;
    logic [9:0]  ev;
    rx = '0;
    tx_data  = b;
    tx_valid = 1'b1;
    step(1);
    acc_edge = cyc;
    m_byte   = b;
    mode     = md;
    end_edge = (md == M_SILENT) ? cyc + IC + 1 + TO : BIG;
    q_edge   = -1;
    for (int f = 1; f <= 11; f++) fall_edge[f] = -1;
    frame_on = 1'b1;
    if (!hold) tx_valid = 1'b0;
    waited = 0;
    while (bus_clk !== 1'b1 && waited < IC + 20) begin
      step(1);
      waited++;
    end
    chk("clk_release", int'(bus_clk), 1);
    chk("start_bit", int'(bus_data), 0);
    if (md != M_SILENT) begin
      h = $urandom_range(20, 40);
      g = $urandom_range(8, 20);
      step(g);
      for (int k = 1; k <= 11; k++) begin
        dev_clk_low  = 1'b1;
        fall_edge[k] = cyc;
        if (md == M_RST && k == 5) begin
          step(7);
          #1 reset = 1'b1;
          #1;
          chk("rst_clk_oe", int'(ps2clk_oe), 0);
          chk("rst_data_oe", int'(ps2data_oe), 0);
          chk("rst_busy", int'(busy), 0);
          frame_on    = 1'b0;
          dev_clk_low = 1'b0;
          tx_valid    = 1'b0;
          @(posedge clk);
          #3 reset = 1'b0;
          @(posedge clk);
          #2;
          return;
        end
        if (md == M_NACK && k == 11) end_edge = cyc + 5;
        step(h);
        dev_clk_low = 1'b0;
        if (k <= 10) rx[k] = bus_data;
        if (k == 10) begin
          step(h / 2);
          dev_data_low = (md == M_ACK);
          step(h - h / 2);
        end else if (k < 11) begin
          step(h);
        end
      end
      step(3);
      dev_data_low = 1'b0;
      if (md == M_ACK) q_edge = cyc;
      ev[7:0] = b;
      ev[8]   = ($countones(b) % 2) == 0;
      ev[9]   = 1'b1;
      chk("frame_bits", int'(rx[10:1]), int'(ev));
      last_rx = rx;
    end
    waited = 0;
    @(negedge clk);
    #1;
    while (!(end_edge != BIG && cyc >= end_edge) && waited < TO + 2 * IC + 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("frame_end_bound", int'(end_edge != BIG && cyc >= end_edge), 1);
    tx_valid = 1'b0;
    @(posedge clk);
    #2;
    frame_on = 1'b0;
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    for (int f = 1; f <= 11; f++) fall_edge[f] = -1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_tx_ready", int'(tx_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_oe", int'({ps2clk_oe, ps2data_oe}), 0);
    chk("reset_pulses", int'({done, nack, timeout}), 0);
    #1 reset = 1'b0;
    step(4);

    send_frame(KBD_CMD_LEDS, M_ACK, 1'b0);
    chk("ed_bits_literal", int'(last_rx), 10'h3ED);
    step(3);
    send_frame(KBD_CMD_ENABLE, M_ACK, 1'b0);
    chk("f4_bits_literal", int'(last_rx), 10'h2F4);
    chk("f4_parity_literal", int'(last_rx[9]), 0);
    step(2);
    send_frame(8'($urandom), M_NACK, 1'b0);
    step(2);
    send_frame(8'($urandom), M_SILENT, 1'b0);
    step(1);
    send_frame(8'($urandom), M_ACK, 1'b0);
    step(2);
    send_frame(8'($urandom), M_RST, 1'b0);
    step(3);
    send_frame(KBD_CMD_RESET, M_ACK, 1'b0);
    chk("ff_bits_literal", int'(last_rx), 10'h3FF);
    step(2);
    send_frame(8'($urandom), M_ACK, 1'b1);
    step(4);
    for (int i = 0; i < 6; i++) begin
      send_frame(8'($urandom), int'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      step($urandom_range(1, 5));
    end
    step(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
